// File: rtl/np_uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO, with a programmable clocks-per-bit divider.
// The line is driven straight from a flop; back-to-back frames share no idle bit.
module np_uart_tx #(
  parameter int unsigned DEFAULT_DIV = 106,
  parameter int unsigned FIFO_AW     = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               DIV_WE,
  input  logic [31:0]        DIV_DI,
  output logic [31:0]        DIV_DO,
  input  logic               TX_VALID,
  input  logic [7:0]         TX_DATA,
  output logic               TX_READY,
  output logic               TX_BUSY,
  output logic [FIFO_AW:0]   FIFO_LEVEL,
  output logic               SERIAL_TX
);

  localparam int unsigned      DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] PTR_ONE  = {{FIFO_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]       mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0] level_s;
  logic             empty_s, full_s, push_s, pop_s;
  logic [7:0]       head_s;

  logic [31:0]      div_q, div_eff_s;
  state_t           state_q;
  logic [7:0]       shift_q;
  logic [31:0]      cnt_q, div_lat_q;
  logic [2:0]       bit_idx_q;
  logic             tx_q, cnt_zero_s;

  // Extra pointer MSB separates full from empty; the difference stays right across wrap.
  assign level_s    = wr_ptr_q - rd_ptr_q;
  assign empty_s    = (level_s == {(FIFO_AW+1){1'b0}});
  assign full_s     = (level_s == FULL_LVL);
  assign push_s     = TX_VALID & ~full_s;
  assign cnt_zero_s = (cnt_q == 32'd0);
  assign pop_s      = ~empty_s & ((state_q == S_IDLE) | ((state_q == S_STOP) & cnt_zero_s));
  assign head_s     = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign wr_ptr_d   = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
  assign rd_ptr_d   = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  assign div_eff_s  = (div_q < 32'd2) ? 32'd2 : div_q;

  assign DIV_DO     = div_q;
  assign FIFO_LEVEL = level_s;
  assign TX_READY   = ~full_s;
  assign TX_BUSY    = (state_q != S_IDLE) | ~empty_s;
  assign SERIAL_TX  = tx_q;

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= TX_DATA;
    end
  end

  // FIFO pointers and divider register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= {(FIFO_AW+1){1'b0}};
      rd_ptr_q <= {(FIFO_AW+1){1'b0}};
      div_q    <= 32'(DEFAULT_DIV);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (DIV_WE) begin
        div_q <= DIV_DI;
      end
    end
  end

  // Frame sequencer; the divider is latched per frame so mid-frame writes wait for the next start bit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      tx_q      <= 1'b1;
      shift_q   <= 8'd0;
      cnt_q     <= 32'd0;
      div_lat_q <= 32'd0;
      bit_idx_q <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop_s) begin
            shift_q   <= head_s;
            cnt_q     <= div_eff_s - 32'd1;
            div_lat_q <= div_eff_s;
            tx_q      <= 1'b0;
            state_q   <= S_START;
          end
        end
        S_START: begin
          if (cnt_zero_s) begin
            tx_q      <= shift_q[0];
            bit_idx_q <= 3'd0;
            cnt_q     <= div_lat_q - 32'd1;
            state_q   <= S_DATA;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_DATA: begin
          if (cnt_zero_s) begin
            cnt_q <= div_lat_q - 32'd1;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              tx_q      <= shift_q[1];
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_STOP: begin
          if (pop_s) begin
            shift_q   <= head_s;
            cnt_q     <= div_eff_s - 32'd1;
            div_lat_q <= div_eff_s;
            tx_q      <= 1'b0;
            state_q   <= S_START;
          end else if (cnt_zero_s) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_np_uart_tx.sv
// Directed self-checking bench for np_uart_tx: reset, single frame, burst, divider changes,
// divider clamping and reset mid-frame.
module tb_np_uart_tx;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        DIV_WE = 1'b0;
  logic [31:0] DIV_DI = 32'd0;
  logic [31:0] DIV_DO;
  logic        TX_VALID = 1'b0;
  logic [7:0]  TX_DATA = 8'd0;
  logic        TX_READY;
  logic        TX_BUSY;
  logic [2:0]  FIFO_LEVEL;
  logic        SERIAL_TX;

  int n_cmp = 0;
  int n_err = 0;

  np_uart_tx #(.DEFAULT_DIV(106), .FIFO_AW(2)) dut (
    .CLK(CLK), .RST(RST), .DIV_WE(DIV_WE), .DIV_DI(DIV_DI), .DIV_DO(DIV_DO),
    .TX_VALID(TX_VALID), .TX_DATA(TX_DATA), .TX_READY(TX_READY), .TX_BUSY(TX_BUSY),
    .FIFO_LEVEL(FIFO_LEVEL), .SERIAL_TX(SERIAL_TX)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    TX_VALID = 1'b1;
    TX_DATA  = b;
    while (!TX_READY && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk("push_timeout", 32'(n), 32'd0);
    tick();
    TX_VALID = 1'b0;
  endtask

  task automatic setdiv(input logic [31:0] v);
    DIV_WE = 1'b1;
    DIV_DI = v;
    tick();
    DIV_WE = 1'b0;
  endtask

  // Receives one frame; checks every cycle of the frame against the ideal waveform.
  task automatic recv(input logic [7:0] exp, input int div, input string tag, output int waits);
    int bad;
    int k;
    logic [7:0] got;
    logic e;
    bad = 0;
    got = 8'd0;
    tick();
    waits = 1;
    while (SERIAL_TX !== 1'b0 && waits < 5000) begin
      tick();
      waits++;
    end
    if (waits >= 5000) begin
      chk({tag, "_start_timeout"}, 32'(waits), 32'd0);
    end else begin
      for (int c = 0; c < 10 * div; c++) begin
        if (c > 0) tick();
        k = c / div;
        e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : exp[k-1];
        if (SERIAL_TX !== e) bad++;
        if (k >= 1 && k <= 8 && (c % div) == div / 2) got[k-1] = SERIAL_TX;
      end
      chk({tag, "_byte"}, 32'(got), 32'(exp));
      chk({tag, "_timing"}, 32'(bad), 32'd0);
    end
  endtask

  initial begin
    int w;
    int lows;

    // Asynchronous reset: outputs must settle before any clock edge
    #2 RST = 1'b1;
    #1;
    chk("rst_tx",    32'(SERIAL_TX),  32'd1);
    chk("rst_ready", 32'(TX_READY),   32'd1);
    chk("rst_busy",  32'(TX_BUSY),    32'd0);
    chk("rst_level", 32'(FIFO_LEVEL), 32'd0);
    chk("rst_div",   DIV_DO,          32'd106);
    repeat (3) tick();
    RST = 1'b0;
    tick();

    // Single byte 0x55 at the default divider
    push(8'h55);
    recv(8'h55, 106, "single", w);
    chk("single_latency", 32'(w), 32'd1);
    chk("single_busy_last", 32'(TX_BUSY), 32'd1);
    tick();
    chk("single_busy_end", 32'(TX_BUSY), 32'd0);
    chk("single_line_idle", 32'(SERIAL_TX), 32'd1);

    // Burst of six bytes: FIFO fills, remaining push is held off, frames back to back
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          push(8'(i));
          if (i == 4) begin
            chk("burst_full_level", 32'(FIFO_LEVEL), 32'd4);
            chk("burst_full_ready", 32'(TX_READY), 32'd0);
          end
        end
      end
      begin
        for (int j = 0; j < 6; j++) begin
          recv(8'(j), 106, $sformatf("burst%0d", j), w);
          if (j > 0) chk($sformatf("burst%0d_gap", j), 32'(w), 32'd1);
        end
      end
    join
    tick();
    chk("burst_done_busy", 32'(TX_BUSY), 32'd0);

    // Divider write during bit 3 of 0xA3 applies only from the next frame
    fork
      begin
        recv(8'hA3, 106, "mid_a3", w);
        recv(8'h3C, 20, "mid_3c", w);
        chk("mid_3c_gap", 32'(w), 32'd1);
      end
      begin
        push(8'hA3);
        push(8'h3C);
        repeat (4 * 106 + 50) tick();
        setdiv(32'd20);
        chk("mid_div_rd", DIV_DO, 32'd20);
      end
    join
    repeat (3) tick();

    // Divider values 0 and 1 clamp to 2 clocks per bit
    setdiv(32'd0);
    chk("div0_rd", DIV_DO, 32'd0);
    push(8'hF0);
    recv(8'hF0, 2, "div0", w);
    chk("div0_latency", 32'(w), 32'd1);
    tick();
    setdiv(32'd1);
    chk("div1_rd", DIV_DO, 32'd1);
    push(8'hF0);
    recv(8'hF0, 2, "div1", w);
    chk("div1_latency", 32'(w), 32'd1);
    repeat (3) tick();

    // Reset while in DATA with three bytes queued
    setdiv(32'd106);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    chk("pre_rst_level", 32'(FIFO_LEVEL), 32'd3);
    repeat (300) tick();
    #3 RST = 1'b1;
    #1;
    chk("mid_rst_tx",    32'(SERIAL_TX),  32'd1);
    chk("mid_rst_level", 32'(FIFO_LEVEL), 32'd0);
    chk("mid_rst_ready", 32'(TX_READY),   32'd1);
    chk("mid_rst_busy",  32'(TX_BUSY),    32'd0);
    chk("mid_rst_div",   DIV_DO,          32'd106);
    tick();
    RST = 1'b0;
    lows = 0;
    for (int c = 0; c < 2500; c++) begin
      tick();
      if (SERIAL_TX !== 1'b1) lows++;
    end
    chk("post_rst_quiet", 32'(lows), 32'd0);
    chk("post_rst_busy", 32'(TX_BUSY), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
